// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle add/sub/logic ops and a WIDTH-step shift-add
// multiplier, with a registered result/flags pair and a tri-state bus output.
module alu_multicycle #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             ClrN,
    input  logic [WIDTH-1:0] Accumulator,
    input  logic [WIDTH-1:0] BRegister,
    input  logic [2:0]       Operation,
    input  logic             AluStart,
    input  logic             ALUOut,
    output tri   [WIDTH-1:0] BusOut,
    output logic [3:0]       Flags,
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned CNT_W  = $clog2(WIDTH + 1);
    localparam int unsigned PROD_W = 2 * WIDTH;
    localparam int unsigned MSB    = WIDTH - 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_INC = 3'b010;
    localparam logic [2:0] OP_DCR = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [3:0]         flags_q, flags_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PROD_W-1:0]  prod_q, prod_d;

    logic [WIDTH-1:0]   opb_c;
    logic [WIDTH:0]     ext_c;
    logic [WIDTH-1:0]   alu_res_c;
    logic               alu_carry_c;
    logic               alu_ovf_c;
    logic [WIDTH:0]     mul_sum_c;
    logic [PROD_W-1:0]  prod_next_c;

    // Single-cycle datapath evaluated on the live operands for the accept edge
    always_comb begin
        opb_c       = ((Operation == OP_INC) || (Operation == OP_DCR)) ? WIDTH'(1) : BRegister;
        ext_c       = '0;
        alu_res_c   = '0;
        alu_carry_c = 1'b0;
        alu_ovf_c   = 1'b0;
        case (Operation)
            OP_ADD, OP_INC: begin
                ext_c       = {1'b0, Accumulator} + {1'b0, opb_c};
                alu_res_c   = ext_c[WIDTH-1:0];
                alu_carry_c = ext_c[WIDTH];
                alu_ovf_c   = (Accumulator[MSB] == opb_c[MSB]) && (ext_c[MSB] != Accumulator[MSB]);
            end
            OP_SUB, OP_DCR: begin
                // bit WIDTH of the extended difference is the borrow
                ext_c       = {1'b0, Accumulator} - {1'b0, opb_c};
                alu_res_c   = ext_c[WIDTH-1:0];
                alu_carry_c = ext_c[WIDTH];
                alu_ovf_c   = (Accumulator[MSB] != opb_c[MSB]) && (ext_c[MSB] != Accumulator[MSB]);
            end
            OP_AND:  alu_res_c = Accumulator & BRegister;
            OP_OR:   alu_res_c = Accumulator | BRegister;
            OP_XOR:  alu_res_c = Accumulator ^ BRegister;
            default: alu_res_c = '0;
        endcase
    end

    // One right-shifting shift-add multiply step; b_q is consumed LSB first
    always_comb begin
        mul_sum_c   = {1'b0, prod_q[PROD_W-1:WIDTH]} + {1'b0, (b_q[0] ? a_q : '0)};
        prod_next_c = {mul_sum_c, prod_q[WIDTH-1:1]};
    end

    // Next-state and datapath register update logic
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        flags_d  = flags_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        case (state_q)
            ST_IDLE: begin
                if (AluStart) begin
                    a_d  = Accumulator;
                    b_d  = BRegister;
                    op_d = Operation;
                    if (Operation == OP_MUL) begin
                        state_d = ST_MUL;
                        cnt_d   = CNT_W'(WIDTH);
                        prod_d  = '0;
                    end else begin
                        state_d  = ST_DONE;
                        result_d = alu_res_c;
                        flags_d  = {(alu_res_c == '0), alu_carry_c, alu_res_c[MSB], alu_ovf_c};
                    end
                end
            end
            ST_MUL: begin
                prod_d = prod_next_c;
                b_d    = b_q >> 1;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = ST_DONE;
                    result_d = prod_next_c[WIDTH-1:0];
                    flags_d  = {(prod_next_c[WIDTH-1:0] == '0),
                                (op_q == OP_MUL) && (prod_next_c[PROD_W-1:WIDTH] != '0),
                                prod_next_c[MSB],
                                1'b0};
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge Clk or negedge ClrN) begin
        if (!ClrN) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            flags_q  <= '0;
            cnt_q    <= '0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
        end
    end

    // Status decoded straight from the state register
    assign Busy  = (state_q != ST_IDLE);
    assign Done  = (state_q == ST_DONE);
    assign Flags = flags_q;

    // Bus driver follows ALUOut only; the held result is visible even while busy
    assign BusOut = ALUOut ? result_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_alu_multicycle.sv
// Randomised self-checking bench for alu_multicycle at WIDTH=8 and WIDTH=16.
module tb_alu_multicycle;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_INC = 3'd2;
    localparam logic [2:0] OP_DCR = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    logic clk;
    logic rst8_n, rst16_n;

    logic [7:0]  a8, b8;
    logic [2:0]  op8;
    logic        start8, oe8;
    wire  [7:0]  bus8;
    logic [3:0]  flags8;
    logic        busy8, done8;

    logic [15:0] a16, b16;
    logic [2:0]  op16;
    logic        start16, oe16;
    wire  [15:0] bus16;
    logic [3:0]  flags16;
    logic        busy16, done16;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0]  prev_res8;
    logic [15:0] prev_res16;

    alu_multicycle #(.WIDTH(8)) dut8 (
        .Clk(clk), .ClrN(rst8_n), .Accumulator(a8), .BRegister(b8), .Operation(op8),
        .AluStart(start8), .ALUOut(oe8), .BusOut(bus8), .Flags(flags8),
        .Busy(busy8), .Done(done8)
    );

    alu_multicycle #(.WIDTH(16)) dut16 (
        .Clk(clk), .ClrN(rst16_n), .Accumulator(a16), .BRegister(b16), .Operation(op16),
        .AluStart(start16), .ALUOut(oe16), .BusOut(bus16), .Flags(flags16),
        .Busy(busy16), .Done(done16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic, returns {Z,C,S,V, result}
    function automatic logic [35:0] model(input logic [2:0] op, input longint a, input longint b, input int w);
        longint m, half, full, sa, sb, sr, res;
        bit c, v;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        full = 0; c = 1'b0; v = 1'b0; sr = 0;
        if (op == OP_INC || op == OP_DCR) b = 1;
        sa = (a >= half) ? a - (m + 1) : a;
        sb = (b >= half) ? b - (m + 1) : b;
        case (op)
            OP_ADD, OP_INC: begin
                full = a + b; c = (full > m);
                sr = sa + sb; v = (sr >= half) || (sr < -half);
            end
            OP_SUB, OP_DCR: begin
                full = a - b; c = (a < b);
                sr = sa - sb; v = (sr >= half) || (sr < -half);
            end
            OP_AND:  full = a & b;
            OP_OR:   full = a | b;
            OP_XOR:  full = a ^ b;
            default: begin full = a * b; c = (full > m); end
        endcase
        res = full & m;
        return {res == 0, c, ((res >> (w - 1)) & 1) == 1, v, 32'(res)};
    endfunction

    task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input bit hold, input bit scramble);
        logic [35:0] e;
        int n;
        int lat;
        e   = model(op, longint'(a), longint'(b), 8);
        lat = (op == OP_MUL) ? 8 : 0;
        @(negedge clk);
        op8 = op; a8 = a; b8 = b; start8 = 1'b1; oe8 = 1'b1;
        @(posedge clk); #1;
        if (!hold) start8 = 1'b0;
        if (op == OP_MUL) check("w8_bus_prev_while_busy", 32'(bus8), 32'(prev_res8));
        if (scramble && !hold) begin
            a8 = 8'($urandom); b8 = 8'($urandom); op8 = 3'($urandom);
        end
        n = 0;
        while (!done8 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("w8_latency", 32'(n), 32'(lat));
        check("w8_busy_at_done", 32'(busy8), 32'd1);
        check("w8_result", 32'(bus8), 32'(e[7:0]));
        check("w8_flags", 32'(flags8), 32'(e[35:32]));
        if (e[7:0] != 8'h00) begin
            oe8 = 1'b0; #1;
            check("w8_bus_released", 32'((bus8 === 8'hzz) || (bus8 === 8'h00)), 32'd1);
            oe8 = 1'b1; #1;
            check("w8_bus_redriven", 32'(bus8), 32'(e[7:0]));
        end
        prev_res8 = e[7:0];
        @(posedge clk); #1;
        check("w8_idle_busy", 32'(busy8), 32'd0);
        check("w8_idle_done", 32'(done8), 32'd0);
        if (hold) begin
            @(posedge clk); #1;
            check("w8_hold_reaccept", 32'(busy8), 32'd1);
            start8 = 1'b0;
            n = 0;
            while (busy8 && n < 40) begin
                @(posedge clk); #1;
                n++;
            end
            check("w8_hold_drain", 32'(busy8), 32'd0);
            check("w8_hold_result", 32'(bus8), 32'(e[7:0]));
        end
    endtask

    task automatic run16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [35:0] e;
        int n;
        e = model(op, longint'(a), longint'(b), 16);
        @(negedge clk);
        op16 = op; a16 = a; b16 = b; start16 = 1'b1; oe16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom);
        n = 0;
        while (!done16 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check("w16_latency", 32'(n), (op == OP_MUL) ? 32'd16 : 32'd0);
        check("w16_result", 32'(bus16), 32'(e[15:0]));
        check("w16_flags", 32'(flags16), 32'(e[35:32]));
        prev_res16 = e[15:0];
        @(posedge clk); #1;
        check("w16_idle_busy", 32'(busy16), 32'd0);
    endtask

    initial begin
        logic [2:0] rop;
        logic [7:0] ra, rb;
        bit         saw_done;

        rst8_n = 1'b0; rst16_n = 1'b0;
        a8 = '0; b8 = '0; op8 = '0; start8 = 1'b0; oe8 = 1'b1;
        a16 = '0; b16 = '0; op16 = '0; start16 = 1'b0; oe16 = 1'b1;
        prev_res8 = '0; prev_res16 = '0;

        #13;
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_flags", 32'(flags8), 32'd0);
        check("rst_bus", 32'(bus8), 32'd0);
        check("rst16_bus", 32'(bus16), 32'd0);
        @(negedge clk);
        rst8_n = 1'b1; rst16_n = 1'b1;

        // Directed corner cases at WIDTH=8
        run8(OP_ADD, 8'hFF, 8'h01, 1'b0, 1'b0);
        check("add_wrap_res", 32'(bus8), 32'h00);
        check("add_wrap_flags", 32'(flags8), 32'b1100);
        run8(OP_SUB, 8'h80, 8'h01, 1'b0, 1'b0);
        check("sub_ovf_res", 32'(bus8), 32'h7F);
        check("sub_ovf_flags", 32'(flags8), 32'b0001);
        run8(OP_SUB, 8'h03, 8'h05, 1'b0, 1'b0);
        check("sub_borrow_res", 32'(bus8), 32'hFE);
        check("sub_borrow_flags", 32'(flags8), 32'b0110);
        run8(OP_MUL, 8'h10, 8'h11, 1'b0, 1'b1);
        check("mul_hi_res", 32'(bus8), 32'h10);
        check("mul_hi_flags", 32'(flags8), 32'b0100);
        run8(OP_MUL, 8'h0C, 8'h0A, 1'b0, 1'b1);
        check("mul_lo_res", 32'(bus8), 32'h78);
        check("mul_lo_flags", 32'(flags8), 32'b0000);
        run8(OP_MUL, 8'h23, 8'h07, 1'b1, 1'b0);
        run8(OP_INC, 8'hFF, 8'h00, 1'b1, 1'b0);
        run8(OP_DCR, 8'h00, 8'h00, 1'b0, 1'b0);

        // Random operations with biased operand corners
        for (int i = 0; i < 80; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            if ($urandom_range(0, 4) == 0) ra = 8'h80;
            if ($urandom_range(0, 4) == 0) rb = 8'hFF;
            if ($urandom_range(0, 6) == 0) ra = 8'h00;
            run8(rop, ra, rb, ($urandom_range(0, 5) == 0), ($urandom_range(0, 1) == 1));
        end

        // Asynchronous clear in the middle of a multiply
        @(negedge clk);
        op8 = OP_MUL; a8 = 8'h10; b8 = 8'h11; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_mul_busy", 32'(busy8), 32'd1);
        @(negedge clk);
        rst8_n = 1'b0; #1;
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_done", 32'(done8), 32'd0);
        check("abort_bus", 32'(bus8), 32'd0);
        check("abort_flags", 32'(flags8), 32'd0);
        @(negedge clk);
        rst8_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done8) saw_done = 1'b1;
        end
        check("abort_no_done", 32'(saw_done), 32'd0);
        check("abort_bus_after", 32'(bus8), 32'd0);
        prev_res8 = 8'h00;
        run8(OP_OR, 8'h5A, 8'h81, 1'b0, 1'b0);

        // WIDTH=16 corners and random
        run16(OP_DCR, 16'h0000, 16'h0000);
        check("dcr16_res", 32'(bus16), 32'hFFFF);
        check("dcr16_flags", 32'(flags16), 32'b0110);
        run16(OP_XOR, 16'hA5A5, 16'hA5A5);
        check("xor16_res", 32'(bus16), 32'h0000);
        check("xor16_flags", 32'(flags16), 32'b1000);
        for (int i = 0; i < 20; i++) begin
            run16(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
